fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares the single write port of the team's FIFO (wr_en/data_in/full) between NUM_REQ producers.
- Each producer presents packets over a valid/ready/last handshake. A grant is held for a whole packet, so beats from different producers never interleave inside the FIFO.
- The block sits between the producer agents' datapaths and the FIFO write pins. The read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter in front of a single FIFO write port.
//
// Handshake: a beat from requester i transfers at a rising clock edge where
// req_valid[i] && req_ready[i]. A requester holds valid/data/last stable until
// that edge; ready never depends on a requester other than the granted one and
// is at most one-hot. The accepted beat appears on fifo_wr_en/fifo_data_in one
// cycle later.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          wr_count
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  // IDLE: free to pick a new packet owner. LOCKED: mid-packet, owner fixed.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [FIFO_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;

  logic [FIFO_WIDTH-1:0] beat [NUM_REQ];
  logic [ID_W-1:0]       sel;
  logic [ID_W-1:0]       cand;
  logic                  sel_found;
  logic                  space_ok;
  logic [ID_W-1:0]       acc_id;
  logic                  accept;
  logic                  acc_last;
  logic [FIFO_WIDTH-1:0] acc_data;

  // Modulo-NUM_REQ increment that also works for non-power-of-two counts.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + ID_W'(1);
  endfunction

  // A write issued this cycle may consume the last free slot, so treat
  // almost-full plus an in-flight write as full.
  assign space_ok = !fifo_full && !(fifo_almost_full && fifo_wr_en_q);

  // Unpack the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      beat[i] = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    sel       = rr_ptr_q;
    sel_found = 1'b0;
    cand      = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!sel_found && req_valid[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
      cand = next_id(cand);
    end
  end

  // FSM next state, ready generation and registered write-port next values.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    req_ready    = '0;
    acc_id       = (state_q == IDLE) ? sel : grant_id_q;

    if (space_ok) begin
      if (state_q == LOCKED) begin
        req_ready[grant_id_q] = 1'b1;
      end else if (sel_found) begin
        req_ready[sel] = 1'b1;
      end
    end

    accept   = |(req_valid & req_ready);
    acc_last = req_last[acc_id];
    acc_data = beat[acc_id];

    fifo_wr_en_d = accept;
    fifo_data_d  = accept ? acc_data : fifo_data_q;
    wr_count_d   = accept ? wr_count_q + CNT_WIDTH'(1) : wr_count_q;

    if (accept) begin
      grant_id_d = acc_id;
      if (acc_last) begin
        // Packet done: the finisher drops to lowest priority.
        state_d  = IDLE;
        rr_ptr_d = next_id(acc_id);
      end else begin
        state_d  = LOCKED;
      end
    end
  end

  // State and output registers; reset abandons any in-flight packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_data_q  <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      fifo_data_q  <= fifo_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_data_in = fifo_data_q;
  assign grant_id     = grant_id_q;
  assign busy         = (state_q == LOCKED);
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat queues drive the inputs, a
// packet-level model predicts every output each cycle, and directed tests pin
// the model with literal expectations.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_almost_full = 1'b0;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic [1:0]     grant_id;
  logic           busy;
  logic [CW-1:0]  wr_count;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .busy(busy), .wr_count(wr_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- driver: per-requester beat queues ----------------
  logic [W-1:0] mem_d [N][64];
  logic         mem_l [N][64];
  int           head [N] = '{default: 0};
  int           tail [N] = '{default: 0};
  int           acc_cnt [N] = '{default: 0};
  logic [N-1:0] pend = '0;

  task automatic push(input int i, input logic [W-1:0] d, input logic l);
    mem_d[i][tail[i]] = d;
    mem_l[i][tail[i]] = l;
    tail[i]++;
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst) head[i] = tail[i];
      else if (pend[i]) begin
        head[i]++;
        acc_cnt[i]++;
      end
      if (!rst && head[i] != tail[i]) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = mem_l[i][head[i]];
        req_data[i*W +: W]   = mem_d[i][head[i]];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*W +: W]   = '0;
      end
    end
  end

  // ---------------- packet-level model ----------------
  logic         m_locked = 1'b0;
  int           m_owner = 0;
  int           m_ptr = 0;
  int           m_grant = 0;
  int           m_cnt = 0;
  logic         m_wr_en = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] exp_q[$];

  // Who may transfer now: the packet owner if one exists, else the first
  // valid requester counting up from the priority pointer; nobody if the
  // FIFO might overflow.
  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int j;
    r = '0;
    if (fifo_full || (fifo_almost_full && m_wr_en)) return r;
    if (m_locked) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (req_valid[j]) begin
        r[j] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_grant = 0;
      m_cnt = 0; m_wr_en = 1'b0; m_data = '0;
      exp_q.delete();
    end else begin : upd
      logic [N-1:0] r;
      int who;
      r   = exp_ready();
      who = -1;
      for (int k = 0; k < N; k++) if (r[k] && req_valid[k]) who = k;
      m_wr_en = (who >= 0);
      if (who >= 0) begin
        m_data = req_data[who*W +: W];
        exp_q.push_back(m_data);
        m_cnt   = (m_cnt + 1) % (1 << CW);
        m_grant = who;
        if (req_last[who]) begin
          m_locked = 1'b0;
          m_ptr    = (who + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner  = who;
        end
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  logic [W-1:0] wr_log [256];
  int           wr_cyc [256];
  int           n_wr = 0;
  int           cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) pend = '0;
    else begin
      check("req_ready", 32'(req_ready), 32'(exp_ready()));
      check("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
      check("busy", 32'(busy), 32'(m_locked));
      check("grant_id", 32'(grant_id), m_grant);
      check("wr_count", 32'(wr_count), m_cnt);
      check("fifo_data_in", fifo_data_in, m_data);
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) fail_now("scoreboard_empty");
        else check("scoreboard", fifo_data_in, exp_q.pop_front());
        if (n_wr < 256) begin
          wr_log[n_wr] = fifo_data_in;
          wr_cyc[n_wr] = cyc;
        end
        n_wr++;
      end
      pend = req_valid & req_ready;
    end
  end

  // ---------------- helper tasks ----------------
  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic wait_acc(input int i, input int target, input int bound);
    int c;
    c = 0;
    while (acc_cnt[i] < target && c < bound) begin
      @(posedge clk); #2;
      c++;
    end
    if (acc_cnt[i] < target) fail_now("wait_acc");
  endtask

  function automatic logic pending();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input int bound);
    int c;
    c = 0;
    while (pending() && c < bound) begin
      @(posedge clk); #2;
      c++;
    end
    if (pending()) fail_now("wait_drain");
    repeat (3) @(posedge clk);
    #2;
  endtask

  // ---------------- directed tests ----------------
  logic [W-1:0] exp_rr [8] = '{32'h10000000, 32'h10000001, 32'h10000100, 32'h10000101,
                               32'h10000200, 32'h10000201, 32'h10000300, 32'h10000301};
  logic [W-1:0] exp_lk [6] = '{32'h30000100, 32'h30000101, 32'h30000102, 32'h30000103,
                               32'h30000200, 32'h30000201};

  initial begin : main
    int base;
    int b0;
    // Reset values while rst is held from time zero.
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_data", fifo_data_in, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_count", 32'(wr_count), 0);
    check("rst_ready", 32'(req_ready), 0);
    @(posedge clk); #2 rst = 1'b0;

    // Reset in the middle of a 5-beat packet from req0.
    do_reset();
    b0 = acc_cnt[0];
    for (int k = 0; k < 5; k++) push(0, 32'h0A000000 + k, k == 4);
    wait_acc(0, b0 + 3, 30);
    rst = 1'b1;
    #1;
    check("midrst_wr_en", 32'(fifo_wr_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_count", 32'(wr_count), 0);
    @(posedge clk); #2 rst = 1'b0;
    base = n_wr;
    push(1, 32'h20000001, 1'b1);
    push(0, 32'h20000000, 1'b1);
    wait_drain(30);
    check("midrst_first", wr_log[base], 32'h20000000);
    check("midrst_second", wr_log[base+1], 32'h20000001);

    // Round robin: everyone has a 2-beat packet ready at once.
    do_reset();
    base = n_wr;
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 2; b++) push(i, 32'h10000000 + i*256 + b, b == 1);
    wait_drain(40);
    check("rr_writes", n_wr - base, 8);
    for (int k = 0; k < 8; k++) check("rr_order", wr_log[base+k], exp_rr[k]);
    check("rr_count", 32'(wr_count), 8);
    check("rr_back_to_back", wr_cyc[base+7] - wr_cyc[base], 7);

    // Packet lock: req1 pauses mid-packet while req2 waits.
    do_reset();
    base = n_wr;
    b0 = acc_cnt[1];
    push(1, 32'h30000100, 1'b0);
    push(1, 32'h30000101, 1'b0);
    push(2, 32'h30000200, 1'b0);
    push(2, 32'h30000201, 1'b1);
    wait_acc(1, b0 + 2, 20);
    repeat (3) begin
      @(negedge clk);
      check("lock_ready2", 32'(req_ready[2]), 0);
      check("lock_grant", 32'(grant_id), 1);
      check("lock_busy", 32'(busy), 1);
    end
    push(1, 32'h30000102, 1'b0);
    push(1, 32'h30000103, 1'b1);
    wait_drain(40);
    check("lock_writes", n_wr - base, 6);
    for (int k = 0; k < 6; k++) check("lock_order", wr_log[base+k], exp_lk[k]);

    // Almost-full guard: a write in flight blocks the next accept.
    do_reset();
    base = n_wr;
    fifo_almost_full = 1'b1;
    push(0, 32'h40000000, 1'b1);
    push(1, 32'h40000001, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("af_ready_first", 32'(req_ready), 32'b0001);
    @(negedge clk);
    check("af_ready_blocked", 32'(req_ready), 0);
    check("af_wr_en", 32'(fifo_wr_en), 1);
    @(negedge clk);
    check("af_ready_next", 32'(req_ready), 32'b0010);
    wait_drain(20);
    fifo_almost_full = 1'b0;
    check("af_writes", n_wr - base, 2);

    // Full backpressure for 5 cycles on req3.
    do_reset();
    base = n_wr;
    fifo_full = 1'b1;
    push(3, 32'hDEADBEEF, 1'b1);
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("full_ready", 32'(req_ready), 0);
      check("full_no_write", 32'(fifo_wr_en), 0);
    end
    @(posedge clk); #2 fifo_full = 1'b0;
    @(negedge clk);
    check("full_release_ready", 32'(req_ready), 32'b1000);
    check("full_release_wr_en", 32'(fifo_wr_en), 0);
    @(negedge clk);
    check("full_write_en", 32'(fifo_wr_en), 1);
    check("full_write_data", fifo_data_in, 32'hDEADBEEF);
    @(negedge clk);
    check("full_single_write", 32'(fifo_wr_en), 0);
    #1;
    check("full_writes", n_wr - base, 1);

    // Counter wrap: 17 single-beat packets on a 4-bit counter.
    do_reset();
    base = n_wr;
    for (int k = 0; k < 17; k++) push(k % N, 32'h60000000 + k, 1'b1);
    wait_drain(80);
    check("wrap_writes", n_wr - base, 17);
    check("wrap_count", 32'(wr_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
